pc_gen: RTL



---
 rtl/pc_gen_pkg.sv | 15 +
 rtl/pc_next_sel.sv | 43 ++++
 rtl/pc_gen.sv | 106 ++++++++++
 3 files changed

// File: rtl/pc_gen_pkg.sv
// Shared fetch-front-end constants and the PC generator state type.
package pc_gen_pkg;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    localparam int unsigned PC_XLEN         = 32;
    localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
    localparam int unsigned PC_INC          = 4;
    localparam int unsigned PC_ALIGN_BITS   = 2;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux (trap > redirect > advance > hold) with redirect alignment check.
module pc_next_sel
    import pc_gen_pkg::*;
#(
    parameter int unsigned XLEN       = PC_XLEN,
    parameter int unsigned INC        = PC_INC,
    parameter int unsigned ALIGN_BITS = PC_ALIGN_BITS
) (
    input  logic [XLEN-1:0] pc_i,
    input  logic            advance_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_target_i,
    input  logic            trap_valid_i,
    input  logic [XLEN-1:0] trap_target_i,
    output logic [XLEN-1:0] pc_next_o,
    output logic            epoch_toggle_o,
    output logic            misalign_o
);

    localparam logic [XLEN-1:0] ALIGN_MASK = (XLEN'(1) << ALIGN_BITS) - XLEN'(1);
    localparam logic [XLEN-1:0] INC_W      = XLEN'(INC);

    always_comb begin
        pc_next_o      = pc_i;
        epoch_toggle_o = 1'b0;
        misalign_o     = 1'b0;
        if (trap_valid_i) begin
            pc_next_o      = trap_target_i & ~ALIGN_MASK;
            epoch_toggle_o = 1'b1;
        end else if (redirect_valid_i) begin
            // A misaligned redirect leaves pc and epoch untouched; the top halts.
            if (|(redirect_target_i & ALIGN_MASK)) begin
                misalign_o = 1'b1;
            end else begin
                pc_next_o      = redirect_target_i;
                epoch_toggle_o = 1'b1;
            end
        end else if (advance_i) begin
            pc_next_o = pc_i + INC_W;
        end
    end

endmodule

// File: rtl/pc_gen.sv
// RV32I fetch PC generator: BOOT/RUN/HALT control, epoch tagging, registered outputs.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned     XLEN         = PC_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(PC_RESET_VECTOR),
    parameter int unsigned     INC          = PC_INC,
    parameter int unsigned     ALIGN_BITS   = PC_ALIGN_BITS
) (
    input  logic            clk,
    input  logic            rst,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    input  logic            pc_ready,
    output logic            epoch,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    output logic            misalign_err,
    output logic            halted
);

    pc_state_e       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            epoch_q, epoch_d;
    logic            pc_valid_q, pc_valid_d;
    logic            misalign_q, misalign_d;
    logic            halted_q, halted_d;

    logic            redirect_en;
    logic            advance;
    logic [XLEN-1:0] sel_pc;
    logic            sel_toggle;
    logic            sel_misalign;

    // Redirects are dropped in HALT; pc_ready only counts while pc is valid.
    assign redirect_en = redirect_valid & (state_q != HALT);
    assign advance     = pc_valid_q & pc_ready;

    pc_next_sel #(
        .XLEN       (XLEN),
        .INC        (INC),
        .ALIGN_BITS (ALIGN_BITS)
    ) u_next_sel (
        .pc_i              (pc_q),
        .advance_i         (advance),
        .redirect_valid_i  (redirect_en),
        .redirect_target_i (redirect_target),
        .trap_valid_i      (trap_valid),
        .trap_target_i     (trap_target),
        .pc_next_o         (sel_pc),
        .epoch_toggle_o    (sel_toggle),
        .misalign_o        (sel_misalign)
    );

    always_comb begin
        state_d    = state_q;
        pc_d       = sel_pc;
        epoch_d    = epoch_q ^ sel_toggle;
        misalign_d = 1'b0;
        unique case (state_q)
            BOOT, RUN: begin
                if (sel_misalign) begin
                    state_d    = HALT;
                    misalign_d = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            HALT: begin
                if (trap_valid) begin
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
        pc_valid_d = (state_d == RUN);
        halted_d   = (state_d == HALT);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_VECTOR;
            epoch_q    <= 1'b0;
            pc_valid_q <= 1'b0;
            misalign_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            epoch_q    <= epoch_d;
            pc_valid_q <= pc_valid_d;
            misalign_q <= misalign_d;
            halted_q   <= halted_d;
        end
    end

    assign pc           = pc_q;
    assign pc_valid     = pc_valid_q;
    assign epoch        = epoch_q;
    assign misalign_err = misalign_q;
    assign halted       = halted_q;

endmodule
